// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared defaults, word type and parity helper for ram_sync
package ram_pkg;

    localparam int RAM_DATA_WIDTH_DEFAULT = 32;
    localparam int RAM_ADDR_WIDTH_DEFAULT = 16;

    // Widest data word the parity helper accepts; narrower words are
    // zero-extended by the caller, which does not change even parity.
    localparam int RAM_PARITY_MAX_WIDTH = 256;

    typedef logic [31:0] ram_word_t;

    // Even-parity bit: 1 when the word holds an odd number of ones, so
    // word plus parity always carries an even count.
    function automatic logic calc_parity(input logic [RAM_PARITY_MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ram_parity_check.sv
// rtl/ram_parity_check.sv - combinational compare of a read word against its stored parity bit
//
// Ports:
//   word           read word straight from the array
//   stored_parity  parity bit written alongside that word
//   parity_err     1 when the recomputed parity disagrees with stored_parity
module ram_parity_check
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  stored_parity,
    output logic                  parity_err
);

    logic [RAM_PARITY_MAX_WIDTH-1:0] word_ext;

    always_comb begin
        word_ext                 = '0;
        word_ext[DATA_WIDTH-1:0] = word;
        parity_err               = calc_parity(word_ext) ^ stored_parity;
    end

endmodule

// File: rtl/ram_sync.sv
// rtl/ram_sync.sv - single-port synchronous word RAM with registered, write-first read data
//
// Optional feature macro: RAM_PARITY_EN (per-word even parity, parity_err output).
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset; clears data_out (and parity_err), not the array
//   address     word address shared by read and write
//   data_in     write data
//   write       write strobe
//   read        read strobe; write+read forwards data_in to data_out
//   data_out    registered read data, one-edge latency, holds while read=0
//   parity_err  (RAM_PARITY_EN only) registered parity mismatch flag for the read word
module ram_sync
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out
`ifdef RAM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (ADDR_WIDTH < 1 || ADDR_WIDTH > 24 || DATA_WIDTH < 1 ||
            DATA_WIDTH > RAM_PARITY_MAX_WIDTH) begin : g_bad_params
            $error("ram_sync: ADDR_WIDTH must be 1..24 and DATA_WIDTH 1..%0d",
                   RAM_PARITY_MAX_WIDTH);
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef RAM_PARITY_EN
    logic                            par_mem [DEPTH];
    logic [RAM_PARITY_MAX_WIDTH-1:0] wr_ext;
    logic                            wr_parity;
    logic                            rd_err;

    always_comb begin
        wr_ext                 = '0;
        wr_ext[DATA_WIDTH-1:0] = data_in;
        wr_parity              = calc_parity(wr_ext);
    end

    ram_parity_check #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_check (
        .word          (mem[address]),
        .stored_parity (par_mem[address]),
        .parity_err    (rd_err)
    );
`endif

    // The array shares the reset block only so that an edge seen while rst
    // is high is fully aborted; the reset branch never touches the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
`ifdef RAM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (write) begin
                mem[address] <= data_in;
`ifdef RAM_PARITY_EN
                par_mem[address] <= wr_parity;
`endif
            end
            if (read) begin
                if (write) begin
                    // Write-first: the old word is never returned.
                    data_out <= data_in;
`ifdef RAM_PARITY_EN
                    parity_err <= 1'b0;
`endif
                end else begin
                    data_out <= mem[address];
`ifdef RAM_PARITY_EN
                    parity_err <= rd_err;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_sync.sv
// tb/tb_ram_sync.sv - table-driven scoreboard bench for ram_sync
module tb_ram_sync;

    logic        clk;
    logic        rst;
    logic [15:0] address;
    logic [31:0] data_in;
    logic        write;
    logic        read;
    logic [31:0] data_out;
`ifdef RAM_PARITY_EN
    logic        parity_err;
`endif

    ram_sync #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .data_in    (data_in),
        .write      (write),
        .read       (read),
        .data_out   (data_out)
`ifdef RAM_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        w;
        logic        r;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] exp_d;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        p;
        string       name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec;
    int   n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic r, input logic [15:0] a,
                       input logic [31:0] d, input logic [31:0] e, input string nm);
        vec_t v;
        v.w = w; v.r = r; v.a = a; v.d = d; v.exp_d = e; v.name = nm;
        tbl.push_back(v);
    endtask

    // Called at posedge+1: drive, queue the expectation, sample one edge later.
    task automatic step(input logic w, input logic r, input logic [15:0] a,
                        input logic [31:0] d, input logic [31:0] ed, input logic ep,
                        input string nm);
        exp_t e;
        write = w; read = r; address = a; data_in = d;
        e.d = ed; e.p = ep; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h, expected an entry", nm, data_out);
        end else begin
            e = sb.pop_front();
            check(e.name, data_out, e.d);
`ifdef RAM_PARITY_EN
            check({e.name, "_perr"}, {31'b0, parity_err}, {31'b0, e.p});
`endif
        end
        write = 1'b0; read = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic flip_p;
        n_vec = 0;
        n_err = 0;
        rst = 1'b0; write = 1'b0; read = 1'b0; address = '0; data_in = '0;

        // Reset asserted mid-clock clears data_out without an edge.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async", data_out, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held", data_out, 32'h0);
        rst = 1'b0;

        add(1, 0, 16'h1234, 32'hDEADBEEF, 32'h00000000, "post_rst_no_read");
        add(0, 1, 16'h1234, 32'h0,        32'hDEADBEEF, "read_1234");
        add(0, 0, 16'h1234, 32'h0,        32'hDEADBEEF, "hold_idle");
        add(1, 0, 16'h1234, 32'h0BADF00D, 32'hDEADBEEF, "write_no_disturb");
        add(0, 1, 16'h1234, 32'h0,        32'h0BADF00D, "read_new_1234");
        add(1, 1, 16'h0001, 32'h12345678, 32'h12345678, "write_first");
        add(1, 0, 16'h0000, 32'hAAAAAAAA, 32'h12345678, "write_lo");
        add(1, 0, 16'hFFFF, 32'h55555555, 32'h12345678, "write_hi");
        add(0, 1, 16'h0000, 32'h0,        32'hAAAAAAAA, "read_lo");
        add(0, 1, 16'hFFFF, 32'h0,        32'h55555555, "read_hi");
        add(0, 1, 16'h0001, 32'h0,        32'h12345678, "read_wf_addr");
        add(0, 1, 16'h1234, 32'h0,        32'h0BADF00D, "reread_1234");
        add(1, 0, 16'h0010, 32'h00000000, 32'h0BADF00D, "write_0010");
        add(1, 0, 16'h8000, 32'hC0FFEE01, 32'h0BADF00D, "write_8000");
        add(0, 1, 16'h0010, 32'h0,        32'h00000000, "read_0010");
        add(0, 1, 16'h8000, 32'h0,        32'hC0FFEE01, "read_8000");

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].exp_d, 1'b0, tbl[i].name);
        end

        // Reset lands on an edge carrying a write; that write must be dropped.
        write = 1'b1; address = 16'h0010; data_in = 32'hFFFFFFFF;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_midop_async", data_out, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        write = 1'b0;
        step(0, 1, 16'h0010, 32'h0, 32'h00000000, 1'b0, "read_after_rst_abort");

`ifdef RAM_PARITY_EN
        dut.par_mem[16'h0010] = ~dut.par_mem[16'h0010];
        flip_p = 1'b1;
`else
        flip_p = 1'b0;
`endif
        step(0, 1, 16'h0010, 32'h0, 32'h00000000, flip_p, "read_flipped_parity");
        step(0, 0, 16'h0010, 32'h0, 32'h00000000, flip_p, "hold_flipped_parity");
        step(1, 1, 16'h0010, 32'h00000007, 32'h00000007, 1'b0, "write_first_clears_perr");
        step(0, 1, 16'h0010, 32'h0, 32'h00000007, 1'b0, "read_rewritten");
        step(0, 1, 16'h0000, 32'h0, 32'hAAAAAAAA, 1'b0, "read_lo_again");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_sync.md
Name: ram_sync

Overview:
- Single-port synchronous word-addressed RAM: one shared address bus, separate write and read strobes, registered read data.
- Used as generic data/instruction storage in the RISC-V CPU. It is the back end behind the memory stages and load/store logic.
- One clock domain. No handshake. Fixed one-cycle read latency.

Parameters:
- DATA_WIDTH, 32, width of each stored word and of data_in/data_out.
- ADDR_WIDTH, 16, word-address width. Depth is 2**ADDR_WIDTH words (default 65536). Must be 1..24.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous active-high reset.
- address  input  ADDR_WIDTH  word address shared by read and write.
- data_in  input  DATA_WIDTH  write data.
- write  input  1  write strobe.
- read  input  1  read strobe.
- data_out  output  DATA_WIDTH  registered read data.
- parity_err  output  1  only present with RAM_PARITY_EN; see Optional Feature.

Behaviour:
- Interface is fixed: one clock, clk; reset is asynchronous and active-high, rst.

Reset:
- While rst=1: data_out=0 immediately, regardless of clk.
- While rst=1: writes and reads are ignored.
- Memory array contents are NOT cleared by reset.
- After power-up, contents are undefined until written.

Write:
- On a rising edge with write=1 and rst=0: mem[address] <= data_in.
- The new value is visible to any read issued on the following edge.

Read:
- On a rising edge with read=1, write=0, rst=0: data_out <= mem[address].
- Latency is one edge: data issued at edge N is valid after edge N and stays stable through edge N+1.

Hold:
- When read=0 (and rst=0), data_out holds its last value indefinitely.
- A write with read=0 never disturbs data_out.

Simultaneous write=1, read=1 (write-first):
- The array is updated with data_in.
- data_out <= data_in at the same edge. Old contents are never returned.

Other boundaries:
- Address decode is full: every address 0 .. 2**ADDR_WIDTH-1 is valid, with no wrap or aliasing.
- Back-to-back accesses every cycle are supported; there are no bubbles.
- Reset asserted mid-stream aborts that edge's access. The array keeps its prior contents.
- Synthesizable as inferred block RAM with an output register. No combinational path from inputs to data_out.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed from data_in at write time.
  - On a read, the stored parity is recomputed against the read word.
  - parity_err is registered alongside data_out with the same latency and hold rules, and resets to 0.
  - parity_err=1 means the parity of the read word mismatched.
  - A write-first forwarded read yields parity_err=0.
- Not defined: the parity_err port and the parity storage are absent. Behaviour is otherwise identical.

Decomposition:
- Package ram_pkg holds:
  - RAM_DATA_WIDTH_DEFAULT=32 and RAM_ADDR_WIDTH_DEFAULT=16.
  - Typedef ram_word_t (logic [31:0]).
  - Function calc_parity, an even-parity reduction used by both the write and check paths.
- Optional sub-module ram_parity_check: combinational parity compare, only instantiated under RAM_PARITY_EN.
- The array and the output register stay in ram_sync.

Test Plan:
- Reset: assert rst for 2 cycles mid-clock → data_out=0 immediately; after release, data_out still 0 until the first read.
- Write/read: write 0xDEADBEEF @0x1234, then next cycle read @0x1234 → data_out=0xDEADBEEF after that edge, held on the following edge with read=0.
- Hold/no disturb: after reading 0xDEADBEEF, write 0x0BADF00D @0x1234 with read=0 → data_out stays 0xDEADBEEF; a subsequent read returns 0x0BADF00D.
- Write-first: write=1, read=1, address 0x0001, data_in 0x12345678 → data_out=0x12345678 at that edge; a later read @0x0001 returns 0x12345678.
- Extremes and back-to-back: write 0xAAAAAAAA @0x0000 and 0x55555555 @0xFFFF; read both on consecutive cycles → outputs 0xAAAAAAAA then 0x55555555, with no aliasing.
- Reset mid-op, with RAM_PARITY_EN: assert rst during a write of 0xFFFFFFFF @0x0010 (old value 0x00000000) → read after release returns 0x00000000 and parity_err=0; force a stored parity bit flip → parity_err=1 on that read.
